// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared constants and helpers for the parametrised sequence
//             detector (length-field width, reset defaults, length clamp).
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

   // Reset-time configuration used when the top-level parameters are left alone.
   localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1011;
   localparam int         DEFAULT_LEN     = 4;
   localparam logic       DEFAULT_OVERLAP = 1'b1;

   // Width of a field able to hold any length 0..max_len.
   function automatic int lw_for(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Clamp a requested pattern length into the legal 1..max_len range.
   function automatic int clamp_len(input int req_len, input int max_len);
      if (req_len < 1) begin
         return 1;
      end else if (req_len > max_len) begin
         return max_len;
      end else begin
         return req_len;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param_if
//  Brief    : Bit-stream, configuration and status bundle of the sequence
//             detector. The master drives data/config, the slave (detector)
//             returns the match pulse, count and armed flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) ();

   localparam int LW = lw_for(MAX_LEN);

   logic               en;
   logic               x;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               z;
   logic [CNT_W-1:0]   match_count;
   logic               armed;

   modport master (
      output en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      input  z, match_count, armed
   );

   modport slave (
      input  en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      output z, match_count, armed
   );

endinterface
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Saturating up-counter with synchronous clear. A clear that
//             coincides with an increment lands on 1 so the event is kept.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter
   import seq_det_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Clear has priority but still records a same-cycle increment; otherwise count up and stick at max.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? CNT_W'(1) : '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Runtime-configurable serial pattern detector. Qualified bits are
//             shifted into a history register; a fill counter tracks how many
//             valid bits it holds. A registered one-cycle pulse flags each
//             match and a saturating counter accumulates them.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN         = 8,
   parameter int                 CNT_W           = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(seq_det_pkg::DEFAULT_PATTERN),
   parameter int                 DEFAULT_LEN     = seq_det_pkg::DEFAULT_LEN,
   parameter logic               DEFAULT_OVERLAP = seq_det_pkg::DEFAULT_OVERLAP
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_detector_param_if.slave  bus
);

   localparam int LW = lw_for(MAX_LEN);

   // Active configuration
   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               overlap;

   // History and status
   logic [MAX_LEN-1:0] shift;
   logic [LW-1:0]      fill;
   logic               z;
   logic               armed;

   // Next-state helpers
   logic               accept;
   logic [MAX_LEN-1:0] nshift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LW-1:0]      nfill;
   logic [LW-1:0]      fill_next;
   logic               hit;
   logic [LW-1:0]      load_len;

   assign accept   = bus.en && !bus.cfg_load;
   assign nshift   = {shift[MAX_LEN-2:0], bus.x};
   assign load_len = LW'(clamp_len(int'(bus.cfg_len), MAX_LEN));

   // Only the low len bits of history and pattern take part in the comparison.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len));
      end
   end

   // Fill saturates at len; a match in non-overlap mode restarts the history count.
   always_comb begin
      nfill     = (fill >= len) ? len : (fill + LW'(1));
      hit       = accept && (nfill == len) && (((nshift ^ pat) & len_mask) == '0);
      fill_next = (hit && !overlap) ? '0 : nfill;
   end

   // Configuration, history, match pulse and armed flag; cfg_load wins over a data bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat     <= DEFAULT_PATTERN;
         len     <= LW'(DEFAULT_LEN);
         overlap <= DEFAULT_OVERLAP;
         shift   <= '0;
         fill    <= '0;
         z       <= 1'b0;
         armed   <= 1'b0;
      end else if (bus.cfg_load) begin
         pat     <= bus.cfg_pattern;
         len     <= load_len;
         overlap <= bus.cfg_overlap;
         shift   <= '0;
         fill    <= '0;
         z       <= 1'b0;
         armed   <= 1'b0;
      end else if (accept) begin
         shift   <= nshift;
         fill    <= fill_next;
         z       <= hit;
         armed   <= (fill_next == len);
      end else begin
         z       <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit),
      .clr   (bus.cnt_clr),
      .count (bus.match_count)
   );

   assign bus.z     = z;
   assign bus.armed = armed;

endmodule
`default_nettype wire
